// File: rtl/output_scan_sequencer_pkg.sv
// Shared types and constants for the output scan sequencer.
// Holds FSM state encodings, the MUX hold code and the table entry layout.
package output_scan_sequencer_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_LOAD  = 2'd1;
  localparam state_t ST_DWELL = 2'd2;

  // sel value that freezes the MUX on its previous channel
  localparam logic [3:0] SEL_HOLD = 4'd15;

  localparam int unsigned DWELL_W_DEF = 24;

  typedef struct packed {
    logic [3:0]             chan;
    logic [DWELL_W_DEF-1:0] dwell;
  } tbl_entry_t;

endpackage

// File: rtl/scan_table_ram.sv
// Scan table storage: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset.
module scan_table_ram
  import output_scan_sequencer_pkg::*;
#(
  parameter int unsigned N_ENT   = 8,
  parameter int unsigned DWELL_W = DWELL_W_DEF,
  localparam int unsigned IW     = $clog2(N_ENT)
) (
  input  logic               clk_i,
  input  logic               wr_en_i,
  input  logic [IW-1:0]      wr_addr_i,
  input  logic [3:0]         wr_chan_i,
  input  logic [DWELL_W-1:0] wr_dwell_i,
  input  logic [IW-1:0]      rd_addr_i,
  output logic [3:0]         rd_chan_o,
  output logic [DWELL_W-1:0] rd_dwell_o
);

  logic [DWELL_W+3:0] mem_q [N_ENT];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= {wr_chan_i, wr_dwell_i};
    end
  end

  // A read in the same cycle as a write to the same index returns the old entry
  assign {rd_chan_o, rd_dwell_o} = mem_q[rd_addr_i];

endmodule

// File: rtl/output_scan_sequencer.sv
// Drives the select of a registered 15:1 output MUX in manual or table-driven scan mode,
// with a per-entry trigger pulse and a valid flag that blanks MUX settling cycles.
module output_scan_sequencer
  import output_scan_sequencer_pkg::*;
#(
  parameter int unsigned N_ENT   = 8,
  parameter int unsigned DWELL_W = DWELL_W_DEF,
  parameter int unsigned SETTLE  = 2,
  localparam int unsigned IW     = $clog2(N_ENT),
  localparam int unsigned SW     = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [3:0]         man_sel,
  input  logic [IW-1:0]      len,
  input  logic               wr_en,
  input  logic [IW-1:0]      wr_addr,
  input  logic [3:0]         wr_chan,
  input  logic [DWELL_W-1:0] wr_dwell,
  output logic [3:0]         sel,
  output logic               valid,
  output logic               trig,
  output logic [IW-1:0]      idx,
  output logic               busy
);

  state_t             state_q, state_d;
  logic [3:0]         sel_q, sel_d;
  logic               trig_q, trig_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [SW-1:0]      settle_q, settle_d;
  logic               valid_q, valid_d;
  logic [3:0]         rd_chan;
  logic [DWELL_W-1:0] rd_dwell;

  scan_table_ram #(
    .N_ENT  (N_ENT),
    .DWELL_W(DWELL_W)
  ) u_tbl (
    .clk_i     (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_chan_i (wr_chan),
    .wr_dwell_i(wr_dwell),
    .rd_addr_i (idx_q),
    .rd_chan_o (rd_chan),
    .rd_dwell_o(rd_dwell)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    trig_d  = 1'b0;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    if (!run) begin
      state_d = ST_IDLE;
      sel_d   = man_sel;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_LOAD;
          sel_d   = man_sel;
          idx_d   = '0;
        end
        ST_LOAD: begin
          state_d = ST_DWELL;
          sel_d   = rd_chan;
          // Zero dwell behaves as one cycle
          cnt_d   = (rd_dwell == '0) ? '0 : rd_dwell - 1'b1;
          trig_d  = 1'b1;
        end
        ST_DWELL: begin
          if (cnt_q == '0) begin
            state_d = ST_LOAD;
            // >= also catches len lowered below the current index mid-scan
            idx_d   = (idx_q >= len) ? '0 : idx_q + 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    settle_d = settle_q;
    if ((sel_d != sel_q) && (sel_d != SEL_HOLD)) begin
      settle_d = SW'(SETTLE);
    end else if (settle_q != '0) begin
      settle_d = settle_q - 1'b1;
    end
    valid_d = (settle_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      trig_q   <= 1'b0;
      idx_q    <= '0;
      cnt_q    <= '0;
      settle_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      trig_q   <= trig_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      valid_q  <= valid_d;
    end
  end

  assign sel   = sel_q;
  assign valid = valid_q;
  assign trig  = trig_q;
  assign idx   = idx_q;
  assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_output_scan_sequencer.sv
// Directed bench for output_scan_sequencer: manual mode, scan timing, abort, write collision,
// hold entries, mid-scan length change and asynchronous reset.
module tb_output_scan_sequencer;

  localparam int unsigned N_ENT   = 8;
  localparam int unsigned DWELL_W = 24;
  localparam int unsigned IW      = 3;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               run;
  logic [3:0]         man_sel;
  logic [IW-1:0]      len;
  logic               wr_en;
  logic [IW-1:0]      wr_addr;
  logic [3:0]         wr_chan;
  logic [DWELL_W-1:0] wr_dwell;
  logic [3:0]         sel;
  logic               valid;
  logic               trig;
  logic [IW-1:0]      idx;
  logic               busy;

  int n_tests = 0;
  int n_fail  = 0;

  output_scan_sequencer #(
    .N_ENT  (N_ENT),
    .DWELL_W(DWELL_W),
    .SETTLE (2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (run),
    .man_sel (man_sel),
    .len     (len),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_chan (wr_chan),
    .wr_dwell(wr_dwell),
    .sel     (sel),
    .valid   (valid),
    .trig    (trig),
    .idx     (idx),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int c, input int d);
    wr_en    = 1'b1;
    wr_addr  = IW'(a);
    wr_chan  = 4'(c);
    wr_dwell = DWELL_W'(d);
    step();
    wr_en    = 1'b0;
  endtask

  task automatic test_reset();
    step();
    n_tests++;
    if ({sel, valid, trig, busy, idx} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: sel=%0d valid=%b trig=%b busy=%b idx=%0d want all 0",
               sel, valid, trig, busy, idx);
    end
    rst_n = 1'b1;
    step();
    n_tests++;
    if (sel !== 4'd0 || valid !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: sel=%0d valid=%b busy=%b want 0 1 0", sel, valid, busy);
    end
  endtask

  task automatic test_manual();
    man_sel = 4'd3;
    step();
    n_tests++;
    if (sel !== 4'd3 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL manual_3: sel=%0d valid=%b want 3 0", sel, valid);
    end
    step();
    step();
    n_tests++;
    if (valid !== 1'b1) begin
      n_fail++;
      $display("FAIL manual_3_settled: valid=%b want 1", valid);
    end
    man_sel = 4'd7;
    step();
    n_tests++;
    if (sel !== 4'd7 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL manual_7: sel=%0d valid=%b want 7 0", sel, valid);
    end
    step();
    n_tests++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL manual_7_blank2: valid=%b want 0", valid);
    end
    step();
    n_tests++;
    if (valid !== 1'b1) begin
      n_fail++;
      $display("FAIL manual_7_settled: valid=%b want 1", valid);
    end
    man_sel = 4'd15;
    step();
    n_tests++;
    if (sel !== 4'd15 || valid !== 1'b1) begin
      n_fail++;
      $display("FAIL manual_hold: sel=%0d valid=%b want 15 1", sel, valid);
    end
    step();
    n_tests++;
    if (valid !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL manual_hold_2: valid=%b busy=%b want 1 0", valid, busy);
    end
  endtask

  task automatic test_scan();
    int exp_sel   [10] = '{2, 2, 2, 2, 2, 5, 5, 9, 9, 2};
    int exp_trig  [10] = '{1, 0, 0, 0, 0, 1, 0, 1, 0, 1};
    int exp_idx   [10] = '{0, 0, 0, 0, 1, 1, 2, 2, 0, 0};
    int exp_valid [10] = '{0, 0, 1, 1, 1, 0, 0, 0, 0, 0};
    wr(0, 2, 4);
    wr(1, 5, 1);
    wr(2, 9, 0);
    len = 3'd2;
    run = 1'b1;
    step();
    n_tests++;
    if (busy !== 1'b1 || sel !== 4'd15 || idx !== 3'd0 || trig !== 1'b0) begin
      n_fail++;
      $display("FAIL scan_start: busy=%b sel=%0d idx=%0d trig=%b want 1 15 0 0",
               busy, sel, idx, trig);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      n_tests++;
      if (sel !== 4'(exp_sel[i]) || trig !== 1'(exp_trig[i]) || idx !== IW'(exp_idx[i]) ||
          valid !== 1'(exp_valid[i]) || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL scan_c%0d: sel=%0d trig=%b idx=%0d valid=%b busy=%b want %0d %0d %0d %0d 1",
                 i + 1, sel, trig, idx, valid, busy,
                 exp_sel[i], exp_trig[i], exp_idx[i], exp_valid[i]);
      end
    end
  endtask

  task automatic test_abort();
    repeat (5) step();
    n_tests++;
    if (sel !== 4'd5 || idx !== 3'd1 || trig !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_pre: sel=%0d idx=%0d trig=%b want 5 1 1", sel, idx, trig);
    end
    run     = 1'b0;
    man_sel = 4'd6;
    step();
    n_tests++;
    if (sel !== 4'd6 || idx !== 3'd0 || trig !== 1'b0 || busy !== 1'b0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: sel=%0d idx=%0d trig=%b busy=%b valid=%b want 6 0 0 0 0",
               sel, idx, trig, busy, valid);
    end
    step();
    step();
    n_tests++;
    if (valid !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_settled: valid=%b want 1", valid);
    end
    run = 1'b1;
    step();
    n_tests++;
    if (busy !== 1'b1 || idx !== 3'd0 || sel !== 4'd6) begin
      n_fail++;
      $display("FAIL restart_load: busy=%b idx=%0d sel=%0d want 1 0 6", busy, idx, sel);
    end
    step();
    n_tests++;
    if (sel !== 4'd2 || trig !== 1'b1 || idx !== 3'd0) begin
      n_fail++;
      $display("FAIL restart_entry0: sel=%0d trig=%b idx=%0d want 2 1 0", sel, trig, idx);
    end
  endtask

  task automatic test_write_collision();
    repeat (4) step();
    n_tests++;
    if (idx !== 3'd1 || trig !== 1'b0) begin
      n_fail++;
      $display("FAIL coll_load1: idx=%0d trig=%b want 1 0", idx, trig);
    end
    wr(1, 11, 3);
    n_tests++;
    if (sel !== 4'd5 || trig !== 1'b1) begin
      n_fail++;
      $display("FAIL coll_old_value: sel=%0d trig=%b want 5 1", sel, trig);
    end
    repeat (9) step();
    n_tests++;
    if (sel !== 4'd11 || trig !== 1'b1 || idx !== 3'd1) begin
      n_fail++;
      $display("FAIL coll_new_value: sel=%0d trig=%b idx=%0d want 11 1 1", sel, trig, idx);
    end
    repeat (3) step();
    n_tests++;
    if (idx !== 3'd2 || trig !== 1'b0 || sel !== 4'd11) begin
      n_fail++;
      $display("FAIL coll_dwell3_end: idx=%0d trig=%b sel=%0d want 2 0 11", idx, trig, sel);
    end
    step();
    n_tests++;
    if (sel !== 4'd9 || trig !== 1'b1) begin
      n_fail++;
      $display("FAIL coll_next_entry: sel=%0d trig=%b want 9 1", sel, trig);
    end
  endtask

  task automatic test_hold_entry();
    wr(0, 15, 3);
    step();
    n_tests++;
    if (sel !== 4'd15 || trig !== 1'b1 || valid !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_entry: sel=%0d trig=%b valid=%b want 15 1 1", sel, trig, valid);
    end
    step();
    n_tests++;
    if (valid !== 1'b1 || sel !== 4'd15) begin
      n_fail++;
      $display("FAIL hold_no_blank: sel=%0d valid=%b want 15 1", sel, valid);
    end
    repeat (3) step();
    n_tests++;
    if (sel !== 4'd11 || trig !== 1'b1 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_exit: sel=%0d trig=%b valid=%b want 11 1 0", sel, trig, valid);
    end
  endtask

  task automatic test_len_change();
    len = 3'd0;
    repeat (3) step();
    n_tests++;
    if (idx !== 3'd0 || trig !== 1'b0) begin
      n_fail++;
      $display("FAIL len_wrap: idx=%0d trig=%b want 0 0", idx, trig);
    end
    step();
    n_tests++;
    if (sel !== 4'd15 || trig !== 1'b1 || idx !== 3'd0) begin
      n_fail++;
      $display("FAIL len_entry0: sel=%0d trig=%b idx=%0d want 15 1 0", sel, trig, idx);
    end
  endtask

  task automatic test_reset_mid_scan();
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({sel, valid, trig, busy, idx} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: sel=%0d valid=%b trig=%b busy=%b idx=%0d want all 0",
               sel, valid, trig, busy, idx);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    run      = 1'b0;
    man_sel  = 4'd0;
    len      = '0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_chan  = '0;
    wr_dwell = '0;
    test_reset();
    test_manual();
    test_scan();
    test_abort();
    test_write_collision();
    test_hold_entry();
    test_len_change();
    test_reset_mid_scan();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
